mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Synthesizable word-memory responder: the target side of the store/retrieve
//   protocol the bench-side initiator drives. Accepts one store or retrieve
//   request at a time over a valid/ready channel and returns retrieve data over
//   a valid/ready response channel after a fixed access latency.
//   Sits behind any initiator issuing (addr, shortint data) transactions.
// PARAMETERS
//   ADDR_W   32   request address width (int-sized)
//   DATA_W   16   data word width (shortint-sized)
//   DEPTH    256  number of words stored; legal addresses 0..DEPTH-1
//   LATENCY  1    wait cycles between accept and memory access; legal 0..15
// PORTS
//   clk        in   1       clock, all state on posedge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept (high only in IDLE)
//   req_write  in   1       1 = store, 0 = retrieve
//   req_addr   in   ADDR_W  word address
//   req_wdata  in   DATA_W  store data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       initiator accepts response
//   rsp_data   out  DATA_W  retrieved word
//   rsp_err    out  1       address was out of range
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
//     Memory array is NOT cleared by reset; contents undefined until written.
//   - States IDLE, WAIT, RESP. One outstanding transaction; req_ready=(state==IDLE).
//   - IDLE: accept on posedge with req_valid&req_ready (edge N); latch write,
//     addr, wdata; load counter=LATENCY. LATENCY>0 -> WAIT, else access at edge N.
//   - WAIT: counter decrements each edge; access at edge N+LATENCY.
//   - Access edge: store writes mem[addr]; retrieve registers rsp_data=mem[addr],
//     rsp_err=0, and enters RESP (rsp_valid visible cycle after edge N+LATENCY).
//     Store returns to IDLE (no response) -> with LATENCY=0 stores stream 1/cycle.
//   - RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_valid&rsp_ready;
//     then rsp_valid=0 and IDLE at that edge. New request accepted next edge.
//   - Out of range (addr >= DEPTH, full ADDR_W compared, no wrap/aliasing):
//     store dropped, memory unchanged; retrieve returns rsp_data=0, rsp_err=1.
//   - Read-after-write coherent: a store is committed before any later retrieve.
//   - rst_n low mid-transaction: abort immediately, outputs to reset values;
//     a store not yet at its access edge is never committed.
// CONFIGURATION
//   MEM_RSP_WRACK_EN defined: stores also enter RESP after access; rsp_data =
//     stored word (0 if out of range), rsp_err as for retrieve; store throughput
//     limited by response handshake.
//   Not defined: stores complete silently as above; no write response.
// TESTING
//   1 reset, store 100<-1024, retrieve 100 (L=1) -> rsp_data=1024, rsp_err=0,
//     rsp_valid 2 cycles after accept edge.
//   2 retrieve with rsp_ready low 5 cycles -> rsp_valid/rsp_data stable,
//     req_ready=0, busy=1; release -> IDLE next edge.
//   3 DEPTH=256: retrieve 256 -> data 0, err 1; store 300<-0x55 then retrieve 44
//     -> old value of 44 (no aliasing).
//   4 LATENCY=0: stores 0..3 <- 10,11,12,13 on consecutive cycles, req_ready held 1;
//     retrieves return 10,11,12,13.
//   5 L=3 store 5<-0xAAAA, rst_n low in WAIT -> rsp_valid=0, req_ready=1 after
//     release; retrieve 5 returns pre-existing value.
//   6 MEM_RSP_WRACK_EN: store 7<-0xBEEF -> response data 0xBEEF err 0;
//     without macro -> no rsp_valid pulse.

Source files
------------

// File: rtl/mem_responder.sv
// Word-memory responder: one store/retrieve in flight, fixed access latency, valid/ready response.
// Optional MEM_RSP_WRACK_EN: stores also return a response carrying the stored word.
module mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RSP_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_en, acc_wr, acc_in_rng;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata, rd_word;
  logic [IW-1:0]       acc_idx;

  // With zero latency the access happens on the accept edge, straight from the request bus.
  always_comb begin
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_wr    = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_in_rng = (acc_addr < ADDR_W'(DEPTH));
  assign acc_idx    = acc_addr[IW-1:0];
  assign rd_word    = mem[acc_idx];
  assign acc_en     = ((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = 4'(LATENCY);
        state_d = (LATENCY == 0) ? IDLE : WAIT;
      end
      WAIT: cnt_d = cnt_q - 4'd1;
      RESP: if (rsp_ready) begin
        state_d    = IDLE;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (acc_en) begin
      if (!acc_wr || WRACK) begin
        state_d    = RESP;
        rsp_data_d = !acc_in_rng ? '0 : (acc_wr ? acc_wdata : rd_word);
        rsp_err_d  = !acc_in_rng;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage is deliberately not reset; an aborted store never reaches acc_en because WAIT is cleared.
  always_ff @(posedge clk) begin
    if (acc_en && acc_wr && acc_in_rng) mem[acc_idx] <= acc_wdata;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances at LATENCY 1, 0 and 3,
// each checked against an array reference memory with randomized traffic and backpressure.
module tb_mem_responder;

  localparam int NI = 3;

  typedef struct {
    int          k;
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [15:0] req_wdata [NI];
  logic        rsp_ready [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic [15:0] rsp_data  [NI];
  logic        rsp_err   [NI];
  logic        busy      [NI];

  logic [15:0] mdl [NI][256];
  exp_t        sbq [$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          rdy_mode = 0;   // 0 always ready, 1 random, 2 never
  logic        pv [NI], pr [NI], pe [NI];
  logic [15:0] pd [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(32), .DATA_W(16), .DEPTH(256),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_err(rsp_err[g]), .busy(busy[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request; the reference memory is updated and the expected response queued at accept.
  task automatic issue(int k, bit w, logic [31:0] a, logic [15:0] d, bit commit = 1'b1);
    int   n;
    bit   in_rng;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
    while (!req_ready[k]) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("req_accept_timeout", 32'd0, 32'd1);
        req_valid[k] = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    in_rng = (a < 32'd256);
    e.k = k; e.due = cyc + lat_of(k); e.err = !in_rng;
    if (w) begin
      if (in_rng && commit) mdl[k][a[7:0]] = d;
      e.data = in_rng ? d : 16'h0;
`ifdef MEM_RSP_WRACK_EN
      sbq.push_back(e);
`endif
    end else begin
      e.data = in_rng ? mdl[k][a[7:0]] : 16'h0;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      for (int k = 0; k < NI; k++)
        rsp_ready[k] = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pop on each new response, hold-stability while stalled, idle after handshake.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        pv[k] = 1'b0; pr[k] = 1'b0;
      end else begin
        if (rsp_valid[k]) begin
          check("rsp_ctrl_ready_busy", {30'd0, req_ready[k], busy[k]}, 32'd1);
          if (pv[k] && !pr[k]) begin
            check("rsp_stable", {15'd0, rsp_err[k], rsp_data[k]}, {15'd0, pe[k], pd[k]});
          end else if (sbq.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_rsp inst=%0d actual=%0h expected=none", k, rsp_data[k]);
          end else begin
            mon_e = sbq.pop_front();
            check("rsp_inst", k, mon_e.k);
            check("rsp_data", {16'd0, rsp_data[k]}, {16'd0, mon_e.data});
            check("rsp_err", {31'd0, rsp_err[k]}, {31'd0, mon_e.err});
            check("rsp_latency", cyc, mon_e.due);
          end
        end else if (pv[k] && pr[k]) begin
          check("post_handshake_idle", {30'd0, req_ready[k], busy[k]}, 32'd2);
        end
        pv[k] = rsp_valid[k]; pr[k] = rsp_ready[k];
        pe[k] = rsp_err[k];   pd[k] = rsp_data[k];
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      rsp_ready[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_req_ready", {31'd0, req_ready[k]}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      check("reset_rsp_data",  {16'd0, rsp_data[k]}, 32'd0);
      check("reset_rsp_err",   {31'd0, rsp_err[k]}, 32'd0);
      check("reset_busy",      {31'd0, busy[k]}, 32'd0);
    end
    rst_n = 1'b1;

    // Give every word a known value so all later retrieves are predictable.
    for (int k = 0; k < NI; k++)
      for (int a = 0; a < 256; a++) issue(k, 1'b1, 32'(a), 16'($urandom));
    drain();

    // Basic store then retrieve at LATENCY 1.
    issue(0, 1'b1, 32'd100, 16'd1024);
    issue(0, 1'b0, 32'd100, 16'd0);
    drain();

    // Response held under backpressure, then released.
    rdy_mode = 2;
    issue(0, 1'b0, 32'd17, 16'd0);
    repeat (7) @(negedge clk);
    check("stall_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
    check("stall_req_ready", {31'd0, req_ready[0]}, 32'd0);
    rdy_mode = 0;
    drain();

    // Out-of-range boundaries, no aliasing onto low addresses.
    issue(0, 1'b0, 32'd256, 16'd0);
    issue(0, 1'b0, 32'd255, 16'd0);
    issue(0, 1'b1, 32'd300, 16'h0055);
    issue(0, 1'b0, 32'd44, 16'd0);
    issue(0, 1'b1, 32'hFFFF_FF2C, 16'h1234);
    issue(0, 1'b0, 32'd44, 16'd0);
    issue(0, 1'b0, 32'h8000_0000, 16'd0);
    drain();

    // Zero latency: back-to-back stores with req_ready never dropping.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_req_ready", {31'd0, req_ready[1]}, 32'd1);
      req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'(i); req_wdata[1] = 16'(10 + i);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      mdl[1][i] = 16'(10 + i);
`ifdef MEM_RSP_WRACK_EN
      mon_e.k = 1; mon_e.data = 16'(10 + i); mon_e.err = 1'b0; mon_e.due = cyc;
      sbq.push_back(mon_e);
`endif
    end
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'(i), 16'd0);
    drain();

    // Reset during the wait phase of a LATENCY 3 store aborts it.
    issue(2, 1'b1, 32'd5, 16'hAAAA, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready[2]}, 32'd1);
    check("abort_busy",      {31'd0, busy[2]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(2, 1'b0, 32'd5, 16'd0);
    drain();

    // Store acknowledgement exists only when the write-response option is built in.
    issue(0, 1'b1, 32'd7, 16'hBEEF);
    repeat (5) @(negedge clk);
    issue(0, 1'b0, 32'd7, 16'd0);
    drain();

    // Randomized traffic with random backpressure on every instance.
    rdy_mode = 1;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 80; n++) begin
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = (r < 8) ? 32'($urandom_range(0, 255)) :
            (r == 8) ? 32'(256 + $urandom_range(0, 100)) : 32'($urandom);
        issue(k, 1'($urandom_range(0, 1)), a, 16'($urandom));
      end
      drain();
    end
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

endmodule
